vec_loader: RTL and testbench

VEC_LOADER -- requirements
Module: vec_loader

---
 rtl/vec_loader_pkg.sv | 26 ++
 rtl/vec_out_reg.sv | 40 ++++
 rtl/vec_loader.sv | 126 ++++++++++++
 tb/tb_vec_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_loader_pkg.sv
// ---------------------------------------------------------------------------
// vec_loader_pkg
//   Constants shared by the vector loader, the vector multiplier and the
//   adder tree: default element width and vector length, the counter-width
//   helper, and the loader FSM state encodings.
// ---------------------------------------------------------------------------
package vec_loader_pkg;

    localparam int unsigned VL_DATA_BW     = 8;
    localparam int unsigned VL_MATRIX_SIZE = 16;

    // Loader FSM states (legacy two-state encoding)
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Smallest w with 2**w >= value; used to size lane counters.
    function automatic int unsigned vl_clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/vec_out_reg.sv
// ---------------------------------------------------------------------------
// vec_out_reg
//   One-entry valid/ready register stage for a packed vector.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid / in_ready   upstream handshake, in_data captured on accept
//     out_valid / out_ready downstream handshake, out_data held while stalled
// ---------------------------------------------------------------------------
module vec_out_reg #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic load;

    // Accepts when empty or when the held entry leaves this cycle.
    assign in_ready = ~out_valid | out_ready;
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vec_loader.sv
// ---------------------------------------------------------------------------
// vec_loader
//   Collects a stream of signed elements into MATRIX_SIZE-lane vectors and
//   presents each completed vector through a one-entry output register.
//   Ports:
//     clk, rst_n                clock, synchronous active-low reset
//     in_valid/in_ready/in_data element stream (k-th element -> lane k)
//     in_last                   short-vector terminator (optional feature)
//     out_valid/out_ready       packed vector handshake
//     out_data_flat             lane k at [k*DATA_BW +: DATA_BW]
//   Build option:
//     VEC_LOADER_SHORT_VEC_EN   in_last completes the vector early and the
//                               unwritten upper lanes read as zero; without
//                               it in_last is ignored.
// ---------------------------------------------------------------------------
module vec_loader
    import vec_loader_pkg::*;
#(
    parameter int unsigned DATA_BW     = VL_DATA_BW,
    parameter int unsigned MATRIX_SIZE = VL_MATRIX_SIZE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_BW-1:0]      in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_BW*MATRIX_SIZE-1:0] out_data_flat
);

    localparam int unsigned      CNT_W     = vl_clog2(MATRIX_SIZE);
    localparam int unsigned      VEC_W     = DATA_BW * MATRIX_SIZE;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(MATRIX_SIZE - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [VEC_W-1:0] asm_vec;
    logic [VEC_W-1:0] vec_next;
    logic [VEC_W-1:0] push_data;
    logic             accept;
    logic             end_of_vec;
    logic             complete;
    logic             push_valid;
    logic             push_ready;

    assign in_ready = rst_n & (state == ST_FILL);
    assign accept   = in_valid & in_ready;

`ifdef VEC_LOADER_SHORT_VEC_EN
    assign end_of_vec = (cnt == LAST_LANE) | in_last;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign end_of_vec     = (cnt == LAST_LANE);
`endif

    assign complete = accept & end_of_vec;

    // Assembly contents including the element offered this cycle. Lanes above
    // the fill position are forced to zero so an early in_last yields a
    // zero-padded vector without a separate clear pass.
    always_comb begin
        vec_next = '0;
        for (int unsigned k = 0; k < MATRIX_SIZE; k++) begin
            if (CNT_W'(k) == cnt) begin
                vec_next[k*DATA_BW +: DATA_BW] = in_data;
            end else if (CNT_W'(k) < cnt) begin
                vec_next[k*DATA_BW +: DATA_BW] = asm_vec[k*DATA_BW +: DATA_BW];
            end
        end
    end

    // A completed vector goes straight to the output register; in HOLD the
    // frozen assembly register is the source instead.
    assign push_valid = (state == ST_HOLD) | complete;
    assign push_data  = (state == ST_HOLD) ? asm_vec : vec_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_FILL;
            cnt     <= '0;
            asm_vec <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (end_of_vec) begin
                            cnt <= '0;
                            if (push_ready) begin
                                asm_vec <= '0;
                            end else begin
                                asm_vec <= vec_next;
                                state   <= ST_HOLD;
                            end
                        end else begin
                            asm_vec <= vec_next;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (push_ready) begin
                        asm_vec <= '0;
                        state   <= ST_FILL;
                    end
                end
            endcase
        end
    end

    vec_out_reg #(
        .WIDTH(VEC_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (push_valid),
        .in_ready (push_ready),
        .in_data  (push_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data_flat)
    );

endmodule

// File: tb/tb_vec_loader.sv
// ---------------------------------------------------------------------------
// tb_vec_loader
//   Self-checking bench for vec_loader (DATA_BW=8, MATRIX_SIZE=16).
//   Honours VEC_LOADER_SHORT_VEC_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_vec_loader;

    localparam int DW = 8;
    localparam int M  = 16;
    localparam int W  = DW * M;

`ifdef VEC_LOADER_SHORT_VEC_EN
    localparam bit SHORT = 1'b1;
`else
    localparam bit SHORT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data_flat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_loader #(
        .DATA_BW    (DW),
        .MATRIX_SIZE(M)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data_flat(out_data_flat)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          exp_irdy;
        logic          exp_ov;
    } row_t;

    row_t tbl[17];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Zero-padded vector from a list of elements, element i in lane i.
    function automatic logic [W-1:0] pack(input logic [DW-1:0] e[$]);
        logic [W-1:0] v;
        v = '0;
        foreach (e[i]) v[i*DW +: DW] = e[i];
        return v;
    endfunction

    function automatic logic [W-1:0] splat(input logic [DW-1:0] x);
        logic [W-1:0] v;
        for (int i = 0; i < M; i++) v[i*DW +: DW] = x;
        return v;
    endfunction

    task automatic do_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] q[$];
        logic [W-1:0]  cap;
        logic [W-1:0]  vec_a;
        logic [W-1:0]  vec_b;
        int            nvalid;

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick;
        tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data_flat, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick;
        chk("post_rst_in_ready", in_ready, 1);

        // ---------------- table: stream 1..16 ----------------
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, DW'(i + 1), 1'b1, 1'b1, (i == 15)};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(DW'(i + 1));
        cap = '0;
        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            in_last   = 1'b0;
            chk($sformatf("t1_in_ready[%0d]", i), in_ready, tbl[i].exp_irdy);
            tick;
            chk($sformatf("t1_out_valid[%0d]", i), out_valid, tbl[i].exp_ov);
            if (i == 15) cap = out_data_flat;
        end
        chk("t1_lane0", cap[7:0], 8'd1);
        chk("t1_lane15", cap[127:120], 8'd16);
        chk("t1_vector", cap, pack(q));

        // ---------------- all -1 passes unchanged ----------------
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            tick;
        end
        in_valid = 1'b0;
        chk("t2_out_valid", out_valid, 1);
        chk("t2_all_ones", out_data_flat, '1);
        tick;
        chk("t2_drained", out_valid, 0);

        // ---------------- backpressure into HOLD ----------------
        q.delete();
        for (int k = 0; k < 16; k++) q.push_back(DW'(k + 17));
        vec_a = pack(q);
        q.delete();
        for (int k = 0; k < 16; k++) q.push_back(DW'(k + 49));
        vec_b = pack(q);
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = (i < 16) ? DW'(i + 17) : DW'(i + 33);
            chk($sformatf("t3_in_ready[%0d]", i), in_ready, 1);
            tick;
            if (i >= 15) begin
                chk($sformatf("t3_out_valid[%0d]", i), out_valid, 1);
                chk($sformatf("t3_stable[%0d]", i), out_data_flat, vec_a);
            end
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h77;
            chk("t3_hold_in_ready", in_ready, 0);
            tick;
            chk("t3_hold_data", out_data_flat, vec_a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("t3_b_valid", out_valid, 1);
        chk("t3_b_data", out_data_flat, vec_b);
        chk("t3_ready_back", in_ready, 1);
        tick;
        chk("t3_b_drained", out_valid, 0);

        // ---------------- reset mid-vector and in HOLD ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd9;
            tick;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick;
        chk("t4_rst_in_ready", in_ready, 0);
        chk("t4_rst_out_valid", out_valid, 0);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd3;
            tick;
        end
        in_valid = 1'b0;
        chk("t4_in_hold", in_ready, 0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        chk("t4_hold_rst_valid", out_valid, 0);
        chk("t4_hold_rst_data", out_data_flat, 0);
        chk("t4_hold_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        nvalid    = 0;
        cap       = '0;
        for (int i = 0; i < 19; i++) begin
            in_valid = (i < 16);
            in_data  = 8'd5;
            tick;
            if (out_valid) begin
                nvalid++;
                cap = out_data_flat;
            end
        end
        chk("t4_one_vector", W'(nvalid), W'(1));
        chk("t4_all_fives", cap, splat(8'd5));

        // ---------------- short vector 3,4,5 ----------------
        do_reset;
        out_ready = 1'b1;
        nvalid    = 0;
        cap       = '0;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 3);
            in_data  = DW'(i + 3);
            in_last  = (i == 2);
            tick;
            if (out_valid) begin
                nvalid++;
                cap = out_data_flat;
            end
        end
        in_last = 1'b0;
        q.delete();
        q.push_back(8'd3);
        q.push_back(8'd4);
        q.push_back(8'd5);
        if (SHORT) begin
            chk("t5_short_count", W'(nvalid), W'(1));
            chk("t5_short_data", cap, pack(q));
        end else begin
            chk("t5_ignored_count", W'(nvalid), W'(0));
        end

        // ---------------- randomized stream vs reference ----------------
        do_reset;
        begin
            logic [DW-1:0] cur[$];
            logic [W-1:0]  expq[$];
            logic [W-1:0]  prev_data;
            logic          prev_stall;
            int            made;
            int            got;
            int            cyc;
            made       = 0;
            got        = 0;
            cyc        = 0;
            prev_stall = 1'b0;
            prev_data  = '0;
            while (got < 100 && cyc < 20000) begin
                if (made < 100) begin
                    in_valid = (($urandom % 4) != 0);
                    in_data  = DW'($urandom);
                    in_last  = (($urandom % 8) == 0);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
                out_ready = (($urandom % 3) != 0);
                if (prev_stall) begin
                    chk("rand_hold_valid", out_valid, 1);
                    chk("rand_hold_data", out_data_flat, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_extra: got %h expected no vector", out_data_flat);
                    end else begin
                        chk($sformatf("rand_vec[%0d]", got), out_data_flat, expq.pop_front());
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    cur.push_back(in_data);
                    if (cur.size() == M || (SHORT && in_last)) begin
                        expq.push_back(pack(cur));
                        cur.delete();
                        made++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data_flat;
                tick;
                cyc++;
            end
            in_valid = 1'b0;
            chk("rand_count", W'(got), W'(100));
            chk("rand_leftover", W'(expq.size()), W'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
